// File: rtl/eth_rx_fcs_check.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | eth_rx_fcs_check : 32-bit receive FCS checker, optional FCS strip        |
// |   (define ETH_RX_FCS_STRIP_EN to remove the 4 FCS bytes from the stream) |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module eth_rx_fcs_check (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in_data,
   input  logic [3:0]  in_keep,
   input  logic        in_valid,
   input  logic        in_last,
   output logic [31:0] out_data,
   output logic [3:0]  out_keep,
   output logic        out_valid,
   output logic        out_last,
   output logic        out_error,
   output logic        stat_frame_good,
   output logic        stat_frame_bad
);

   localparam logic [31:0] C_CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] C_CRC_RESIDUE = 32'hDEBB_20E3;
   localparam logic [31:0] C_CRC_POLY_RF = 32'hEDB8_8320;

   function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
      logic [31:0] c;
      c = crc ^ {24'd0, b};
      for (int i = 0; i < 8; i++)
         c = c[0] ? ((c >> 1) ^ C_CRC_POLY_RF) : (c >> 1);
      return c;
   endfunction

   logic [31:0] r_crc;
   logic [31:0] w_crc_next;
   logic        w_good;

   logic [31:0] w_nx_data;
   logic [3:0]  w_nx_keep;
   logic        w_nx_valid;
   logic        w_nx_last;
   logic        w_nx_error;
   logic        w_nx_good;
   logic        w_nx_bad;

   // in_keep is contiguous from bit 0, so a per-byte enable keeps wire order
   always_comb begin
      w_crc_next = r_crc;
      for (int n = 0; n < 4; n++)
         if (in_keep[n])
            w_crc_next = crc_byte(w_crc_next, in_data[8*n +: 8]);
   end

   assign w_good = (w_crc_next == C_CRC_RESIDUE);

   always_ff @(posedge clk) begin
      if (!rst)
         r_crc <= C_CRC_INIT;
      else if (in_valid)
         r_crc <= in_last ? C_CRC_INIT : w_crc_next;
   end

`ifdef ETH_RX_FCS_STRIP_EN
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_hold;
   logic        w_capture;

   function automatic logic [31:0] keep_mask(input logic [3:0] k);
      return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_capture)
            r_hold <= in_data;
      end
   end

   // One word is always held back so the trailing FCS word can be dropped
   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_nx_valid   = 1'b0;
      w_nx_data    = '0;
      w_nx_keep    = '0;
      w_nx_last    = 1'b0;
      w_nx_error   = 1'b0;
      w_nx_good    = 1'b0;
      w_nx_bad     = 1'b0;
      if (in_valid) begin
         case (r_state)
            ST_IDLE: begin
               if (in_last) begin
                  w_nx_bad = 1'b1;
               end else begin
                  w_capture    = 1'b1;
                  w_state_next = ST_HOLD;
               end
            end
            ST_HOLD: begin
               w_nx_valid = 1'b1;
               if (!in_last) begin
                  w_nx_data = r_hold;
                  w_nx_keep = 4'b1111;
                  w_capture = 1'b1;
               end else begin
                  w_nx_data    = r_hold & keep_mask(in_keep);
                  w_nx_keep    = in_keep;
                  w_nx_last    = 1'b1;
                  w_nx_error   = !w_good;
                  w_nx_good    = w_good;
                  w_nx_bad     = !w_good;
                  w_state_next = ST_IDLE;
               end
            end
            default: w_state_next = ST_IDLE;
         endcase
      end
   end
`else
   always_comb begin
      w_nx_valid = 1'b0;
      w_nx_data  = '0;
      w_nx_keep  = '0;
      w_nx_last  = 1'b0;
      w_nx_error = 1'b0;
      w_nx_good  = 1'b0;
      w_nx_bad   = 1'b0;
      if (in_valid) begin
         w_nx_valid = 1'b1;
         w_nx_data  = in_data;
         w_nx_keep  = in_keep;
         w_nx_last  = in_last;
         w_nx_error = in_last & !w_good;
         w_nx_good  = in_last & w_good;
         w_nx_bad   = in_last & !w_good;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid       <= 1'b0;
         out_data        <= '0;
         out_keep        <= '0;
         out_last        <= 1'b0;
         out_error       <= 1'b0;
         stat_frame_good <= 1'b0;
         stat_frame_bad  <= 1'b0;
      end else begin
         out_valid       <= w_nx_valid;
         out_data        <= w_nx_data;
         out_keep        <= w_nx_keep;
         out_last        <= w_nx_last;
         out_error       <= w_nx_error;
         stat_frame_good <= w_nx_good;
         stat_frame_bad  <= w_nx_bad;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_fcs_check.sv
`default_nettype none
// Randomized frame-level bench for eth_rx_fcs_check with directed anchor frames.
module tb_eth_rx_fcs_check;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] in_data = '0;
   logic [3:0]  in_keep = '0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic        out_valid;
   logic        out_last;
   logic        out_error;
   logic        stat_frame_good;
   logic        stat_frame_bad;

   always #5 clk = ~clk;

   eth_rx_fcs_check dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_keep(in_keep), .in_valid(in_valid), .in_last(in_last),
      .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid), .out_last(out_last),
      .out_error(out_error), .stat_frame_good(stat_frame_good), .stat_frame_bad(stat_frame_bad)
   );

   typedef logic [7:0] bq_t[$];
   typedef logic [37:0] ow_t;   // {data, keep, last, error}
   typedef struct { int stamp; logic [31:0] data; logic [3:0] keep; logic last; logic err; } oexp_t;
   typedef struct { int stamp; logic good; } sexp_t;

   oexp_t oq[$];
   sexp_t sq[$];
   ow_t   olog[$];
   ow_t   r23[$];
   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   bit    mon_en = 1'b0;
   oexp_t e_cur;
   sexp_t s_cur;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Standard Ethernet FCS of the first n bytes (transmitted LSB byte first)
   function automatic logic [31:0] fcs_of(input bq_t b, input int n);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {24'd0, b[i]};
         for (int j = 0; j < 8; j++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return ~c;
   endfunction

   function automatic logic frame_good(input bq_t b);
      int n;
      n = b.size();
      if (n < 4) return 1'b0;
      return (fcs_of(b, n - 4) == {b[n-1], b[n-2], b[n-3], b[n-4]});
   endfunction

   function automatic ow_t ol(input int i);
      if (i < olog.size()) return olog[i];
      return '0;
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         if (oq.size() != 0 && oq[0].stamp < cyc) begin
            chk("word_missing_at", 64'(cyc), 64'(oq[0].stamp));
            void'(oq.pop_front());
         end
         if (sq.size() != 0 && sq[0].stamp < cyc) begin
            chk("stat_missing_at", 64'(cyc), 64'(sq[0].stamp));
            void'(sq.pop_front());
         end
         if (out_valid) begin
            olog.push_back({out_data, out_keep, out_last, out_error});
            if (oq.size() == 0) begin
               chk("word_unexpected", 64'(out_valid), 64'(0));
            end else begin
               e_cur = oq.pop_front();
               chk("word_cycle", 64'(cyc), 64'(e_cur.stamp));
               chk("word_data", 64'(out_data), 64'(e_cur.data));
               chk("word_keep", 64'(out_keep), 64'(e_cur.keep));
               chk("word_last", 64'(out_last), 64'(e_cur.last));
               if (e_cur.last) chk("word_error", 64'(out_error), 64'(e_cur.err));
            end
         end else begin
            chk("idle_outputs_zero", {out_data, out_keep, out_last, out_error}, 64'(0));
         end
         if (stat_frame_good && stat_frame_bad) begin
            chk("stat_both", 64'(1), 64'(0));
         end else if (stat_frame_good || stat_frame_bad) begin
            if (sq.size() == 0) begin
               chk("stat_unexpected", 64'(1), 64'(0));
            end else begin
               s_cur = sq.pop_front();
               chk("stat_cycle", 64'(cyc), 64'(s_cur.stamp));
               chk("stat_good", 64'(stat_frame_good), 64'(s_cur.good));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         in_valid = 1'b0;
         in_last  = 1'b0;
         in_data  = '0;
         in_keep  = '0;
      end
   endtask

   // Drives one frame and queues what the block must produce for it.
   task automatic send_frame(input bq_t b, input int gmin, input int gmax,
                             input int abort_after, input bit garbage);
      int    n;
      int    nw;
      int    st;
      logic  good;
      oexp_t e;
      sexp_t s;
      n    = b.size();
      nw   = (n + 3) / 4;
      good = frame_good(b);
      for (int w = 0; w < nw; w++) begin
         if (abort_after >= 0 && w == abort_after) begin
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
            rst      = 1'b0;
            tick();
            rst = 1'b1;
            return;
         end
         if (w > 0) idle($urandom_range(gmax, gmin));
         tick();
         in_valid = 1'b1;
         in_last  = (w == nw - 1);
         for (int i = 0; i < 4; i++) begin
            if (4*w + i < n) begin
               in_data[8*i +: 8] = b[4*w + i];
               in_keep[i] = 1'b1;
            end else begin
               in_data[8*i +: 8] = garbage ? 8'($urandom) : 8'h00;
               in_keep[i] = 1'b0;
            end
         end
         st = cyc + 1;
`ifdef ETH_RX_FCS_STRIP_EN
         if (w > 0) begin
            e.stamp = st;
            e.data  = '0;
            e.keep  = '0;
            for (int i = 0; i < 4; i++)
               if (4*(w-1) + i < n - 4) begin
                  e.data[8*i +: 8] = b[4*(w-1) + i];
                  e.keep[i] = 1'b1;
               end
            e.last = (w == nw - 1);
            e.err  = !good;
            oq.push_back(e);
         end
         if (w == nw - 1) begin
            s.stamp = st;
            s.good  = (n > 4) && good;
            sq.push_back(s);
         end
`else
         e.stamp = st;
         e.data  = in_data;
         e.keep  = in_keep;
         e.last  = (w == nw - 1);
         e.err   = !good;
         oq.push_back(e);
         if (w == nw - 1) begin
            s.stamp = st;
            s.good  = good;
            sq.push_back(s);
         end
`endif
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      bq_t f;
      bq_t fb;
      bq_t p;
      bq_t r;
      logic [31:0] fcs;
      int n;
      int nw;
      int ab;
      int nexp;
      int na;

      f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
`ifdef ETH_RX_FCS_STRIP_EN
      r23.push_back({32'h3433_3231, 4'hF, 1'b0, 1'b0});
      r23.push_back({32'h3837_3635, 4'hF, 1'b0, 1'b0});
      r23.push_back({32'h0000_0039, 4'h1, 1'b1, 1'b0});
`else
      r23.push_back({32'h3433_3231, 4'hF, 1'b0, 1'b0});
      r23.push_back({32'h3837_3635, 4'hF, 1'b0, 1'b0});
      r23.push_back({32'hF439_2639, 4'hF, 1'b0, 1'b0});
      r23.push_back({32'h0000_00CB, 4'h1, 1'b1, 1'b0});
`endif
      nexp = r23.size();

      chk("model_fcs_123456789", 64'(fcs_of(f, 9)), 64'(32'hCBF4_3926));
      chk("model_good_123456789", 64'(frame_good(f)), 64'(1));

      repeat (3) tick();
      chk("reset_outputs", {out_valid, out_data, out_keep, out_last, out_error,
                            stat_frame_good, stat_frame_bad}, 64'(0));
      mon_en = 1'b1;
      rst    = 1'b1;

      // Check-value frame
      olog.delete();
      send_frame(f, 0, 0, -1, 1'b0);
      idle(3);
      chk("r23_count", 64'(olog.size()), 64'(nexp));
      for (int i = 0; i < nexp; i++) chk("r23_word", 64'(ol(i)), 64'(r23[i]));

      // Same frame with one data bit flipped
      fb = f;
      fb[0] = fb[0] ^ 8'h01;
      olog.delete();
      send_frame(fb, 0, 0, -1, 1'b0);
      idle(3);
      chk("r24_count", 64'(olog.size()), 64'(nexp));
      chk("r24_w0", 64'(ol(0)), 64'({32'h3433_3230, 4'hF, 1'b0, 1'b0}));
      chk("r24_tail", 64'(ol(nexp - 1)), 64'(r23[nexp - 1] | 38'h1));

      // 8-byte payload plus FCS
      p.delete();
      for (int i = 0; i < 8; i++) p.push_back(8'($urandom));
      fcs = fcs_of(p, 8);
      for (int i = 0; i < 4; i++) p.push_back(fcs[8*i +: 8]);
      olog.delete();
      send_frame(p, 0, 0, -1, 1'b0);
      idle(3);
`ifdef ETH_RX_FCS_STRIP_EN
      chk("r25_count", 64'(olog.size()), 64'(2));
      chk("r25_tail", 64'(ol(1) & 38'h3F), 64'({4'hF, 1'b1, 1'b0}));
`else
      chk("r25_count", 64'(olog.size()), 64'(3));
      chk("r25_tail", 64'(ol(2)), 64'({fcs, 4'hF, 1'b1, 1'b0}));
`endif

      // Single-word runt
      p = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      olog.delete();
      send_frame(p, 0, 0, -1, 1'b0);
      idle(3);
`ifdef ETH_RX_FCS_STRIP_EN
      chk("r26_count", 64'(olog.size()), 64'(0));
`else
      chk("r26_count", 64'(olog.size()), 64'(1));
      chk("r26_word", 64'(ol(0)), 64'({32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1}));
`endif

      // Gapped frame immediately followed by a second copy
      olog.delete();
      send_frame(f, 1, 3, -1, 1'b0);
      send_frame(f, 1, 3, -1, 1'b0);
      idle(3);
      chk("r27_count", 64'(olog.size()), 64'(2 * nexp));
      for (int i = 0; i < 2 * nexp; i++) chk("r27_word", 64'(ol(i)), 64'(r23[i % nexp]));

      // Reset after the second word, then the full frame again
      olog.delete();
      send_frame(f, 0, 0, 2, 1'b0);
      send_frame(f, 0, 0, -1, 1'b0);
      idle(3);
`ifdef ETH_RX_FCS_STRIP_EN
      na = 1;
`else
      na = 2;
`endif
      chk("r28_count", 64'(olog.size()), 64'(na + nexp));
      chk("r28_aborted_w0", 64'(ol(0)), 64'(r23[0]));
      for (int i = 0; i < nexp; i++) chk("r28_resent", 64'(ol(na + i)), 64'(r23[i]));

      // Random frames, random gaps, occasional aborts
      for (int k = 0; k < 40; k++) begin
         n = $urandom_range(40, 1);
         p.delete();
         for (int i = 0; i < n; i++) p.push_back(8'($urandom));
         if (n >= 5 && $urandom_range(1, 0) == 1) begin
            fcs = fcs_of(p, n - 4);
            for (int i = 0; i < 4; i++) p[n - 4 + i] = fcs[8*i +: 8];
         end
         nw = (n + 3) / 4;
         ab = -1;
         if (nw >= 2 && $urandom_range(9, 0) == 0) ab = $urandom_range(nw - 1, 1);
         send_frame(p, 0, 2, ab, 1'b1);
         if ($urandom_range(3, 0) == 0) idle($urandom_range(3, 1));
      end

      idle(10);
      chk("drain_words", 64'(oq.size()), 64'(0));
      chk("drain_stats", 64'(sq.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
